dvi_pixel_feeder: RTL
=====================

Name: dvi_pixel_feeder

Overview:
Parametrised pixel feeder between the frame-buffer read port and the DVI ODDR stage. It fetches WORD_W-bit words with a request/valid handshake and buffers them in a FIFO_DEPTH-entry FIFO. During each active (non-border) clock it emits one PIX_W-bit slice to the ODDR stage. It generalises the earlier fixed two-slice offset toggle to N slices per word, adds prefetch during blanking, frame-start resync with in-flight discard, and underflow reporting.

Parameters:
WORD_W, 64, width of frame-buffer word
PIX_W, 32, width of one output slice; WORD_W must be a multiple of PIX_W (SLICES = WORD_W/PIX_W, SLICES >= 2, power of 2)
FIFO_DEPTH, 4, word FIFO entries, power of 2, >= 2

Ports:
clock  input  1  system/pixel clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  high once IIC init done; while low there are no requests and no pops
border  input  1  high outside active video (from SyncGen)
frame_start  input  1  one-cycle pulse at start of vertical sync
request  output  1  one-cycle fetch pulse for one word
word_valid  input  1  returned word strobe, arbitrary latency >= 1 cycle after request, in order
word_data  input  WORD_W  returned word
pix_data  output  PIX_W  current slice to ODDR
pix_valid  output  1  pix_data is a real pixel
underflow  output  1  sticky: active cycle found FIFO empty; cleared by frame_start
overflow  output  1  sticky: word_valid arrived with FIFO full and no discard pending; cleared by frame_start
fifo_level  output  clog2(FIFO_DEPTH)+1  words currently held

Behaviour:
- Reset (reset=0, async): all outputs 0; FIFO empty; offset=0; pending=0; discard=0.
- pending counts requests issued but not yet returned. request=1 when enable && fifo_level+pending < FIFO_DEPTH. Issuing a request increments pending. A word_valid decrements pending; on a same-cycle request and word_valid, pending is unchanged.
- Requests are allowed during border (prefetch) and during active video.
- Push: word_valid && discard==0 writes word_data at the tail. If the FIFO is full, the word is dropped and overflow is set.
- Pop/slice: on a cycle with enable && !border && !frame_start:
  - If the FIFO is non-empty: pix_data <= head[WORD_W-1-offset*PIX_W -: PIX_W] (slice 0 = MSBs); pix_valid <= 1; offset <= offset+1. When offset==SLICES-1, offset wraps to 0 and the head is popped the same cycle.
  - If the FIFO is empty: pix_data <= 0; pix_valid <= 0; underflow <= 1; offset unchanged.
- Output latency is 1 cycle from the active cycle to pix_data/pix_valid. During border or !enable, pix_valid <= 0 and pix_data holds its value.
- A simultaneous pop and push on a full FIFO is legal; the level stays unchanged.
- frame_start, which has priority over pop:
  - Flush the FIFO, set offset=0, and set discard <= pending (minus 1 if word_valid is also this cycle).
  - Clear underflow and overflow; set pix_valid <= 0.
  - While discard>0, each word_valid is dropped and decrements discard.
  - Requests may resume on the next cycle.
- enable falling mid-line: no new requests or pops. Outstanding words are still accepted and the state is kept.
- fifo_level is registered and reflects pushes and pops of the previous edge.

Optional Feature:
FEEDER_PIXEL_DOUBLE_EN: when defined, each slice is held for 2 consecutive active cycles (a 1-bit phase toggles; offset advances only on phase=1), giving horizontal 2x scaling. The phase resets on frame_start and reset. When undefined, the phase logic is absent and each slice lasts 1 active cycle.

Test Plan:
- Reset and fill: release reset with enable=1, border=1, word returned 2 cycles after each request -> exactly 4 request pulses; fifo_level reaches 4; pix_valid stays 0.
- Slicing: head=64'hAAAA_AAAA_5555_5555 and border falls -> pix_data=32'hAAAAAAAA then 32'h55555555 on the next two cycles; fifo_level drops by 1 after the second slice.
- Underflow: withhold word_valid and hold border=0 for 10 cycles -> pix_valid=0 and pix_data=0 once the FIFO is empty; underflow=1 until frame_start.
- Frame resync: pulse frame_start with pending=3 -> the next 3 word_valids are discarded; fifo_level=0; offset=0; underflow and overflow=0; the next active slice is the MSB half of the 4th returned word.
- Simultaneous events: word_valid on the same cycle as a last-slice pop with the FIFO full -> no overflow; fifo_level stays 4.
- FEEDER_PIXEL_DOUBLE_EN defined, word 64'h1111_1111_2222_2222 -> pix_data sequence 11111111, 11111111, 22222222, 22222222.

Source files
------------

// File: rtl/dvi_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module   : dvi_pixel_feeder
// Brief    : Fetches frame-buffer words into a small FIFO and emits one PIX_W
//            slice per active clock to the DVI ODDR stage. Optional macro
//            FEEDER_PIXEL_DOUBLE_EN holds each slice for two active cycles.
// Revision : 1.0
// ============================================================================
module dvi_pixel_feeder #(
  parameter int WORD_W     = 64,
  parameter int PIX_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        border,
  input  logic                        frame_start,
  output logic                        request,
  input  logic                        word_valid,
  input  logic [WORD_W-1:0]           word_data,
  output logic [PIX_W-1:0]            pix_data,
  output logic                        pix_valid,
  output logic                        underflow,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int SLICES = WORD_W / PIX_W;
  localparam int OFF_W  = $clog2(SLICES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W:0]   DEPTH_SUM = (LVL_W+1)'(FIFO_DEPTH);
  localparam logic [OFF_W-1:0] LAST_OFF  = OFF_W'(SLICES - 1);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d, pending_q, pending_d, discard_q, discard_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [PIX_W-1:0]  pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic              underflow_q, underflow_d, overflow_q, overflow_d;
  logic              alive_q;

  logic [WORD_W-1:0] head_word;
  logic [PIX_W-1:0]  head_slice;
  logic [LVL_W:0]    in_use;
  logic              active, fifo_empty, fifo_full, push, pop, slice_done, ret_counted;

`ifdef FEEDER_PIXEL_DOUBLE_EN
  logic phase_q, phase_d;
  assign slice_done = phase_q;
`else
  assign slice_done = 1'b1;
`endif

  assign head_word   = mem_q[rd_ptr_q];
  assign fifo_empty  = (level_q == '0);
  assign fifo_full   = (level_q == DEPTH_LVL);
  assign active      = enable && !border && !frame_start;
  assign ret_counted = word_valid && (pending_q != '0);
  assign in_use      = {1'b0, level_q} + {1'b0, pending_q};

  // alive_q keeps request low for the first cycle out of reset
  assign request = alive_q && enable && !frame_start && (in_use < DEPTH_SUM);

  always_comb begin
    head_slice = '0;
    for (int s = 0; s < SLICES; s++) begin
      if (offset_q == OFF_W'(s)) head_slice = head_word[WORD_W-1-s*PIX_W -: PIX_W];
    end
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pending_d   = pending_q;
    discard_d   = discard_q;
    offset_d    = offset_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    pop         = 1'b0;
`ifdef FEEDER_PIXEL_DOUBLE_EN
    phase_d     = phase_q;
`endif

    if (request && !ret_counted)      pending_d = pending_q + LVL_W'(1);
    else if (!request && ret_counted) pending_d = pending_q - LVL_W'(1);

    if (frame_start) begin
      // Words already in flight belong to the old frame and must be dropped
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      offset_d    = '0;
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
      discard_d   = ret_counted ? pending_q - LVL_W'(1) : pending_q;
`ifdef FEEDER_PIXEL_DOUBLE_EN
      phase_d     = 1'b0;
`endif
    end else begin
      if (active) begin
        if (!fifo_empty) begin
          pix_data_d  = head_slice;
          pix_valid_d = 1'b1;
`ifdef FEEDER_PIXEL_DOUBLE_EN
          phase_d     = ~phase_q;
`endif
          if (slice_done) begin
            if (offset_q == LAST_OFF) begin
              offset_d = '0;
              pop      = 1'b1;
            end else begin
              offset_d = offset_q + OFF_W'(1);
            end
          end
        end else begin
          pix_data_d  = '0;
          underflow_d = 1'b1;
        end
      end

      if (word_valid) begin
        if (discard_q != '0)        discard_d  = discard_q - LVL_W'(1);
        else if (!fifo_full || pop) push       = 1'b1;
        else                        overflow_d = 1'b1;
      end

      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) begin
        mem_d[wr_ptr_q] = word_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pending_q   <= '0;
      discard_q   <= '0;
      offset_q    <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      alive_q     <= 1'b0;
`ifdef FEEDER_PIXEL_DOUBLE_EN
      phase_q     <= 1'b0;
`endif
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pending_q   <= pending_d;
      discard_q   <= discard_d;
      offset_q    <= offset_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      alive_q     <= 1'b1;
`ifdef FEEDER_PIXEL_DOUBLE_EN
      phase_q     <= phase_d;
`endif
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign underflow  = underflow_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule
`default_nettype wire
